// File: rtl/rc4_decrypt_core.sv
// RC4 decrypt engine: S-box init, key schedule, then keystream XOR of an
// encrypted ROM into a result RAM, with optional plaintext-validity abort.
module rc4_decrypt_core #(
  parameter int KEY_BYTES = 3,
  parameter int MSG_DEPTH = 32,
  parameter int MSG_AW    = $clog2(MSG_DEPTH),
  parameter int RD_LAT    = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [KEY_BYTES*8-1:0] key,
  input  logic [MSG_AW:0]        msg_len,
  input  logic                   check_en,
  output logic                   busy,
  output logic                   done,
  output logic                   key_ok,
  output logic [7:0]             s_addr,
  output logic [7:0]             s_wdata,
  output logic                   s_wren,
  input  logic [7:0]             s_rdata,
  output logic [MSG_AW-1:0]      enc_addr,
  input  logic [7:0]             enc_rdata,
  output logic [MSG_AW-1:0]      dec_addr,
  output logic [7:0]             dec_wdata,
  output logic                   dec_wren
);

  localparam int KIW = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
  localparam int WCW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [MSG_AW:0] L_DEPTH = (MSG_AW+1)'(MSG_DEPTH);
  localparam logic [MSG_AW:0] L_ONE   = (MSG_AW+1)'(1);
  localparam logic [KIW-1:0]  L_KLAST = KIW'(KEY_BYTES-1);
  localparam logic [WCW-1:0]  L_WLAST = WCW'(RD_LAT-1);

  localparam logic [4:0] S_IDLE    = 5'd0;
  localparam logic [4:0] S_INIT    = 5'd1;
  localparam logic [4:0] S_KSA_RDI = 5'd2;
  localparam logic [4:0] S_KSA_WI  = 5'd3;
  localparam logic [4:0] S_KSA_CJ  = 5'd4;
  localparam logic [4:0] S_KSA_WJ  = 5'd5;
  localparam logic [4:0] S_KSA_SWJ = 5'd6;
  localparam logic [4:0] S_KSA_SWI = 5'd7;
  localparam logic [4:0] S_KSA_NXT = 5'd8;
  localparam logic [4:0] S_PR_I    = 5'd9;
  localparam logic [4:0] S_PR_WI   = 5'd10;
  localparam logic [4:0] S_PR_CJ   = 5'd11;
  localparam logic [4:0] S_PR_WJ   = 5'd12;
  localparam logic [4:0] S_PR_SWJ  = 5'd13;
  localparam logic [4:0] S_PR_SWI  = 5'd14;
  localparam logic [4:0] S_PR_WS   = 5'd15;
  localparam logic [4:0] S_PR_F    = 5'd16;
  localparam logic [4:0] S_PR_WF   = 5'd17;
  localparam logic [4:0] S_PR_XOR  = 5'd18;
  localparam logic [4:0] S_PR_WD   = 5'd19;
  localparam logic [4:0] S_PR_NXT  = 5'd20;
  localparam logic [4:0] S_DONE    = 5'd21;

  logic [4:0]             r_state;
  logic [7:0]             r_i;
  logic [7:0]             r_j;
  logic [7:0]             r_si;
  logic [7:0]             r_sj;
  logic [7:0]             r_enc;
  logic [MSG_AW:0]        r_k;
  logic [MSG_AW:0]        r_len;
  logic [KIW-1:0]         r_kidx;
  logic [KEY_BYTES*8-1:0] r_key;
  logic                   r_chk;
  logic                   r_ok;
  logic [WCW-1:0]         r_wcnt;

  logic                   r_busy;
  logic                   r_done;
  logic                   r_key_ok;
  logic [7:0]             r_s_addr;
  logic [7:0]             r_s_wdata;
  logic                   r_s_wren;
  logic [MSG_AW-1:0]      r_enc_addr;
  logic [MSG_AW-1:0]      r_dec_addr;
  logic [7:0]             r_dec_wdata;
  logic                   r_dec_wren;

  logic [7:0]      w_kb [KEY_BYTES];
  logic [7:0]      w_kbyte;
  logic [7:0]      w_jk;
  logic [7:0]      w_jp;
  logic [MSG_AW:0] w_len;
  logic            w_wlast;
  logic [WCW-1:0]  w_wcnt_nx;
  logic            w_klast;
  logic            w_bad;

  for (genvar g = 0; g < KEY_BYTES; g++) begin : g_kb
    assign w_kb[g] = r_key[(KEY_BYTES-1-g)*8 +: 8];
  end

  function automatic logic f_valid(input logic [7:0] b);
    return ((b >= 8'h61) && (b <= 8'h7a)) || (b == 8'h20);
  endfunction

  assign w_kbyte   = w_kb[r_kidx];
  assign w_jk      = r_j + s_rdata + w_kbyte;
  assign w_jp      = r_j + s_rdata;
  assign w_len     = (msg_len > L_DEPTH) ? L_DEPTH : msg_len;
  assign w_wlast   = (r_wcnt == L_WLAST);
  assign w_wcnt_nx = w_wlast ? '0 : r_wcnt + WCW'(1);
  assign w_klast   = ((r_k + L_ONE) == r_len);
  // the byte just written is still on dec_wdata, so test it there
  assign w_bad     = r_chk && !f_valid(r_dec_wdata);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_i         <= '0;
      r_j         <= '0;
      r_si        <= '0;
      r_sj        <= '0;
      r_enc       <= '0;
      r_k         <= '0;
      r_len       <= '0;
      r_kidx      <= '0;
      r_key       <= '0;
      r_chk       <= 1'b0;
      r_ok        <= 1'b0;
      r_wcnt      <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_key_ok    <= 1'b0;
      r_s_addr    <= '0;
      r_s_wdata   <= '0;
      r_s_wren    <= 1'b0;
      r_enc_addr  <= '0;
      r_dec_addr  <= '0;
      r_dec_wdata <= '0;
      r_dec_wren  <= 1'b0;
    end else begin
      r_s_wren   <= 1'b0;
      r_dec_wren <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_key    <= key;
            r_len    <= w_len;
            r_chk    <= check_en;
            r_busy   <= 1'b1;
            r_key_ok <= 1'b0;
            r_i      <= '0;
            r_state  <= S_INIT;
          end
        end
        S_INIT: begin
          r_s_addr  <= r_i;
          r_s_wdata <= r_i;
          r_s_wren  <= 1'b1;
          r_i       <= r_i + 8'd1;
          if (r_i == 8'hff) begin
            r_j     <= '0;
            r_kidx  <= '0;
            r_state <= S_KSA_RDI;
          end
        end
        S_KSA_RDI: begin
          r_s_addr <= r_i;
          r_state  <= S_KSA_WI;
        end
        S_KSA_WI: begin
          r_wcnt <= w_wcnt_nx;
          if (w_wlast) r_state <= S_KSA_CJ;
        end
        S_KSA_CJ: begin
          r_si     <= s_rdata;
          r_j      <= w_jk;
          r_s_addr <= w_jk;
          r_state  <= S_KSA_WJ;
        end
        S_KSA_WJ: begin
          r_wcnt <= w_wcnt_nx;
          if (w_wlast) r_state <= S_KSA_SWJ;
        end
        S_KSA_SWJ: begin
          r_sj      <= s_rdata;
          r_s_addr  <= r_j;
          r_s_wdata <= r_si;
          r_s_wren  <= 1'b1;
          r_state   <= S_KSA_SWI;
        end
        S_KSA_SWI: begin
          r_s_addr  <= r_i;
          r_s_wdata <= r_sj;
          r_s_wren  <= 1'b1;
          r_state   <= S_KSA_NXT;
        end
        S_KSA_NXT: begin
          r_i    <= r_i + 8'd1;
          r_kidx <= (r_kidx == L_KLAST) ? '0 : r_kidx + KIW'(1);
          if (r_i == 8'hff) begin
            r_j <= '0;
            r_k <= '0;
            if (r_len == '0) begin
              r_ok    <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_state <= S_PR_I;
            end
          end else begin
            r_state <= S_KSA_RDI;
          end
        end
        S_PR_I: begin
          r_i        <= r_i + 8'd1;
          r_s_addr   <= r_i + 8'd1;
          r_enc_addr <= r_k[MSG_AW-1:0];
          r_state    <= S_PR_WI;
        end
        S_PR_WI: begin
          r_wcnt <= w_wcnt_nx;
          if (w_wlast) r_state <= S_PR_CJ;
        end
        S_PR_CJ: begin
          r_si     <= s_rdata;
          r_enc    <= enc_rdata;
          r_j      <= w_jp;
          r_s_addr <= w_jp;
          r_state  <= S_PR_WJ;
        end
        S_PR_WJ: begin
          r_wcnt <= w_wcnt_nx;
          if (w_wlast) r_state <= S_PR_SWJ;
        end
        S_PR_SWJ: begin
          r_sj      <= s_rdata;
          r_s_addr  <= r_j;
          r_s_wdata <= r_si;
          r_s_wren  <= 1'b1;
          r_state   <= S_PR_SWI;
        end
        S_PR_SWI: begin
          r_s_addr  <= r_i;
          r_s_wdata <= r_sj;
          r_s_wren  <= 1'b1;
          r_state   <= S_PR_WS;
        end
        S_PR_WS: r_state <= S_PR_F;
        S_PR_F: begin
          r_s_addr <= r_si + r_sj;
          r_state  <= S_PR_WF;
        end
        S_PR_WF: begin
          r_wcnt <= w_wcnt_nx;
          if (w_wlast) r_state <= S_PR_XOR;
        end
        S_PR_XOR: begin
          r_dec_addr  <= r_k[MSG_AW-1:0];
          r_dec_wdata <= r_enc ^ s_rdata;
          r_dec_wren  <= 1'b1;
          r_state     <= S_PR_WD;
        end
        S_PR_WD: r_state <= S_PR_NXT;
        S_PR_NXT: begin
          if (w_bad) begin
            r_ok    <= 1'b0;
            r_state <= S_DONE;
          end else if (w_klast) begin
            r_ok    <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_k     <= r_k + L_ONE;
            r_state <= S_PR_I;
          end
        end
        S_DONE: begin
          r_done   <= 1'b1;
          r_busy   <= 1'b0;
          r_key_ok <= r_ok;
          r_state  <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign key_ok    = r_key_ok;
  assign s_addr    = r_s_addr;
  assign s_wdata   = r_s_wdata;
  assign s_wren    = r_s_wren;
  assign enc_addr  = r_enc_addr;
  assign dec_addr  = r_dec_addr;
  assign dec_wdata = r_dec_wdata;
  assign dec_wren  = r_dec_wren;

endmodule

// File: tb/tb_rc4_decrypt_core.sv
// Bench for rc4_decrypt_core: two instances (3- and 5-byte keys) with
// memory models, checked against a plain-arithmetic RC4 reference.
module tb_rc4_decrypt_core;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        st3, chk3, busy3, done3, ok3, swe3, dwe3, clr3;
  logic [23:0] key3;
  logic [5:0]  len3;
  logic [7:0]  sa3, swd3, srd3, erd3, dwd3;
  logic [4:0]  ea3, da3;

  logic        st5, chk5, busy5, done5, ok5, swe5, dwe5, clr5;
  logic [39:0] key5;
  logic [5:0]  len5;
  logic [7:0]  sa5, swd5, srd5, erd5, dwd5;
  logic [4:0]  ea5, da5;

  rc4_decrypt_core u_dut3 (
    .clk(clk), .rst_n(rst_n), .start(st3), .key(key3),
    .msg_len(len3), .check_en(chk3), .busy(busy3), .done(done3),
    .key_ok(ok3), .s_addr(sa3), .s_wdata(swd3), .s_wren(swe3),
    .s_rdata(srd3), .enc_addr(ea3), .enc_rdata(erd3),
    .dec_addr(da3), .dec_wdata(dwd3), .dec_wren(dwe3)
  );

  rc4_decrypt_core #(.KEY_BYTES(5)) u_dut5 (
    .clk(clk), .rst_n(rst_n), .start(st5), .key(key5),
    .msg_len(len5), .check_en(chk5), .busy(busy5), .done(done5),
    .key_ok(ok5), .s_addr(sa5), .s_wdata(swd5), .s_wren(swe5),
    .s_rdata(srd5), .enc_addr(ea5), .enc_rdata(erd5),
    .dec_addr(da5), .dec_wdata(dwd5), .dec_wren(dwe5)
  );

  logic [7:0] smem3 [256];
  logic [7:0] emem3 [32];
  logic [7:0] dmem3 [32];
  int swn3 = 0, dwn3 = 0;
  always @(posedge clk) begin
    if (clr3) for (int n = 0; n < 32; n++) dmem3[n] <= 8'hee;
    if (swe3) smem3[sa3] <= swd3;
    if (dwe3) dmem3[da3] <= dwd3;
    srd3 <= smem3[sa3];
    erd3 <= emem3[ea3];
    if (clr3) begin
      swn3 <= 0;
      dwn3 <= 0;
    end else begin
      if (swe3) swn3 <= swn3 + 1;
      if (dwe3) dwn3 <= dwn3 + 1;
    end
  end

  logic [7:0] smem5 [256];
  logic [7:0] emem5 [32];
  logic [7:0] dmem5 [32];
  int dwn5 = 0;
  always @(posedge clk) begin
    if (clr5) for (int n = 0; n < 32; n++) dmem5[n] <= 8'hee;
    if (swe5) smem5[sa5] <= swd5;
    if (dwe5) dmem5[da5] <= dwd5;
    srd5 <= smem5[sa5];
    erd5 <= emem5[ea5];
    if (clr5) dwn5 <= 0;
    else if (dwe5) dwn5 <= dwn5 + 1;
  end

  int vec = 0;
  int bad = 0;
  int t3, t5;
  logic [7:0] msbox [256];
  logic [7:0] mks [64];
  logic [7:0] pt [32];
  logic [7:0] rfc [8] = '{8'hb2, 8'h39, 8'h63, 8'h05,
                          8'hf0, 8'h3d, 8'hc0, 8'h27};

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    vec++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // plain RC4: KSA then n keystream bytes; msbox keeps the final table
  task automatic rc4_ref(input logic [39:0] k, input int kb, input int n);
    int i, j, m;
    logic [7:0] t;
    for (int x = 0; x < 256; x++) msbox[x] = 8'(x);
    j = 0;
    for (int x = 0; x < 256; x++) begin
      m = int'((k >> ((kb - 1 - (x % kb)) * 8)) & 40'hff);
      j = (j + int'(msbox[x]) + m) % 256;
      t = msbox[x]; msbox[x] = msbox[j]; msbox[j] = t;
    end
    if (n == 0) return;
    i = 0; j = 0;
    for (int x = 0; x < n; x++) begin
      i = (i + 1) % 256;
      j = (j + int'(msbox[i])) % 256;
      t = msbox[i]; msbox[i] = msbox[j]; msbox[j] = t;
      mks[x] = msbox[(int'(msbox[i]) + int'(msbox[j])) % 256];
    end
  endtask

  function automatic bit txt(input logic [7:0] b);
    return (b == 8'h20) || (b >= "a" && b <= "z");
  endfunction

  task automatic go3(input logic [23:0] k, input int len, input logic ce);
    @(negedge clk);
    clr3 = 1'b1; key3 = k; len3 = 6'(len); chk3 = ce; st3 = 1'b1;
    t3 = cyc;
    @(negedge clk);
    clr3 = 1'b0; st3 = 1'b0;
  endtask

  task automatic wait3(input string tag, input int exp_cyc);
    for (int w = 0; w < 4000 && !done3; w++) @(negedge clk);
    chk({tag, "_done"}, 64'(done3), 64'd1);
    chk({tag, "_cyc"}, 64'(cyc - t3), 64'(exp_cyc));
    chk({tag, "_busy"}, 64'(busy3), 64'd0);
  endtask

  task automatic cmp_dec3(input string tag, input int n);
    int d = 0;
    for (int x = 0; x < n; x++)
      if (dmem3[x] !== (emem3[x] ^ mks[x])) d++;
    chk(tag, 64'(d), 64'd0);
  endtask

  task automatic load3(input logic [23:0] k);
    rc4_ref({16'h0, k}, 3, 32);
    for (int x = 0; x < 32; x++) emem3[x] = 8'($urandom);
  endtask

  initial begin
    logic [23:0] k, k2;
    int nb, idx, nw;
    rst_n = 1'b0;
    st3 = 0; chk3 = 0; key3 = 0; len3 = 0; clr3 = 0;
    st5 = 0; chk5 = 0; key5 = 0; len5 = 0; clr5 = 0;
    repeat (3) @(negedge clk);
    chk("rst3", {busy3, done3, ok3, swe3, dwe3, sa3, swd3, ea3, da3, dwd3}, 0);
    chk("rst5", {busy5, done5, ok5, swe5, dwe5, sa5, swd5, ea5, da5, dwd5}, 0);
    rst_n = 1'b1;

    go3(24'h000249, 0, 1'b0);
    chk("busy_on", 64'(busy3), 64'd1);
    for (int w = 0; w < 400 && swn3 < 256; w++) @(negedge clk);
    chk("init_cyc", 64'(cyc - t3), 64'd258);
    nb = 0;
    for (int x = 0; x < 256; x++) if (smem3[x] !== 8'(x)) nb++;
    chk("init_sbox", 64'(nb), 64'd0);
    wait3("len0", 2050);
    chk("len0_ok", 64'(ok3), 64'd1);
    chk("len0_dw", 64'(dwn3), 64'd0);
    chk("len0_sw", 64'(swn3), 64'd768);
    rc4_ref(40'h000249, 3, 0);
    nb = 0;
    for (int x = 0; x < 256; x++) if (smem3[x] !== msbox[x]) nb++;
    chk("ksa_sbox", 64'(nb), 64'd0);
    @(negedge clk);
    chk("done_pulse", 64'(done3), 64'd0);
    chk("ok_hold", 64'(ok3), 64'd1);

    for (int x = 0; x < 32; x++) emem5[x] = 8'h00;
    @(negedge clk);
    clr5 = 1'b1; key5 = 40'h0102030405; len5 = 6'd8; chk5 = 1'b0; st5 = 1'b1;
    t5 = cyc;
    @(negedge clk);
    clr5 = 1'b0; st5 = 1'b0;
    for (int w = 0; w < 4000 && !done5; w++) @(negedge clk);
    chk("rfc_done", 64'(done5), 64'd1);
    chk("rfc_cyc", 64'(cyc - t5), 64'd2146);
    chk("rfc_ok", 64'(ok5), 64'd1);
    chk("rfc_dw", 64'(dwn5), 64'd8);
    for (int x = 0; x < 8; x++)
      chk($sformatf("rfc[%0d]", x), 64'(dmem5[x]), 64'(rfc[x]));

    k = 24'($urandom);
    rc4_ref({16'h0, k}, 3, 32);
    for (int x = 0; x < 32; x++) begin
      pt[x] = ($urandom_range(0, 7) == 0) ? 8'h20 : 8'("a" + $urandom_range(0, 25));
      emem3[x] = pt[x] ^ mks[x];
    end
    go3(k, 32, 1'b1);
    wait3("good", 2434);
    chk("good_ok", 64'(ok3), 64'd1);
    chk("good_dw", 64'(dwn3), 64'd32);
    for (int x = 0; x < 32; x++)
      chk($sformatf("pt[%0d]", x), 64'(dmem3[x]), 64'(pt[x]));

    k2 = k + 24'd1 + 24'($urandom_range(0, 1000));
    rc4_ref({16'h0, k2}, 3, 32);
    idx = -1;
    for (int x = 0; x < 32; x++)
      if (idx < 0 && !txt(emem3[x] ^ mks[x])) idx = x;
    nw = (idx < 0) ? 32 : idx + 1;
    go3(k2, 32, 1'b1);
    wait3("wrong", 2050 + 12 * nw);
    chk("wrong_ok", 64'(ok3), 64'(idx < 0));
    chk("wrong_dw", 64'(dwn3), 64'(nw));
    cmp_dec3("wrong_dec", nw);

    k = 24'($urandom);
    load3(k);
    go3(k, 40, 1'b0);
    wait3("clamp", 2434);
    chk("clamp_ok", 64'(ok3), 64'd1);
    chk("clamp_dw", 64'(dwn3), 64'd32);
    cmp_dec3("clamp_dec", 32);

    go3(24'($urandom), 16, 1'b0);
    for (int w = 0; w < 600 && (cyc - t3) < 500; w++) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_mid", {busy3, done3, ok3, swe3, dwe3, sa3, swd3, ea3, da3, dwd3}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    k = 24'($urandom);
    load3(k);
    go3(k, 16, 1'b0);
    repeat (100) @(negedge clk);
    st3 = 1'b1; key3 = ~key3; len3 = 6'd3; chk3 = 1'b1;
    @(negedge clk);
    st3 = 1'b0;
    wait3("rerun", 2242);
    chk("rerun_ok", 64'(ok3), 64'd1);
    chk("rerun_dw", 64'(dwn3), 64'd16);
    chk("rerun_sw", 64'(swn3), 64'd800);
    cmp_dec3("rerun_dec", 16);

    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end

endmodule
